serial_sub8: RTL and testbench

SERIAL_SUB8 -- requirements
Module: serial_sub8

---
 rtl/serial_sub8_pkg.sv | 19 +
 rtl/serial_sub8_fullsubtractor.sv | 25 ++
 rtl/serial_sub8.sv | 101 ++++++++++
 tb/tb_serial_sub8.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/serial_sub8_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SUB_WIDTH = 8;
  localparam int SUB_CNT_W = $clog2(SUB_WIDTH + 1);

endpackage

// File: rtl/serial_sub8_fullsubtractor.sv
// One-bit full subtractor built from gate primitives:
// diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output wire  diff,
  output wire  bout
);

  wire w_axb;
  wire w_na;
  wire w_nab;
  wire w_xn;
  wire w_xnb;

  xor g_axb  (w_axb, a, b);
  xor g_diff (diff, w_axb, bin);
  not g_na   (w_na, a);
  and g_nab  (w_nab, w_na, b);
  not g_xn   (w_xn, w_axb);
  and g_xnb  (w_xnb, w_xn, bin);
  or  g_bout (bout, w_nab, w_xnb);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// and reports the result with a one-cycle done pulse.
module serial_sub8
  import serial_sub8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_br;
  logic               r_bout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_d;
  logic               w_bo;
  logic               w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:              w_next = ST_IDLE;
      default:              w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  fullsubtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_bo)
  );

  // Operands shift right so bit 0 always feeds the subtractor; result
  // bits enter at the MSB so the word is aligned after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_cnt  <= '0;
            r_diff <= '0;
          end
        end
        ST_SHIFT: begin
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_br   <= w_bo;
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) r_bout <= w_bo;
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and randomized self-checking bench for serial_sub8.
module tb_serial_sub8;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int n_cmp = 0;
  int n_err = 0;

  serial_sub8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; with noise set, start stays high and the operand
  // inputs change every cycle while the op is running.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input bit noise,
                       input logic [7:0] exp_diff, input logic exp_bout);
    int lat;
    int busy_bad;
    int extra;
    bit got;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busyE"}, 32'(busy), 32'd1);
    check({tag, "_diffclr"}, 32'(diff), 32'd0);
    start = noise;
    lat = 0; got = 1'b0; busy_bad = 0;
    while (!got && lat < 30) begin
      if (noise) begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else if (!busy) busy_bad++;
    end
    start = 1'b0;
    check({tag, "_gotdone"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(WIDTH));
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_bout"}, 32'(bout), 32'(exp_bout));
    check({tag, "_busyrun"}, 32'(busy_bad), 32'd0);
    check({tag, "_busydone"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_donew"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    if (noise) begin
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_extra"}, 32'(extra), 32'd0);
      check({tag, "_hold"}, 32'(diff), 32'(exp_diff));
    end
  endtask

  initial begin
    logic [8:0] full;
    int gap;
    int dones;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("op5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0);
    do_op("op0001", 8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1);
    do_op("opffff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_op("op0000b", 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);
    do_op("opff00", 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0);
    do_op("opc335", 8'hC3, 8'h35, 1'b1, 1'b0, 8'h8D, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_diff", 32'(diff), 32'h8D);
    check("hold_bout", 32'(bout), 32'd0);

    do_op("noise", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b0);

    // Abort at edge E+4; start raised alongside reset must be ignored.
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    rst = 1'b0; start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_quiet", 32'(dones), 32'd0);
    do_op("post_abort", 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      do_op("rnd", ra, rb, rbin, 1'b0, full[7:0], full[8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
